// File: rtl/fir_add_sched.sv
// fir_add_sched: sequences NUM_PARTS partial results through one shared FPU
// adder. The sum runs strictly in order, starting with part[0]. The block does
// no arithmetic itself. It only presents operands and stores each returned sum.
// Optional feature macro: FIR_ADD_SCHED_PASS_EN. When it is defined, a new
// sample set offered in DONE with out_ready high is accepted on the same
// cycle as the output handshake.
module fir_add_sched #(
  parameter int NUM_PARTS = 80,
  parameter int FLOAT_W   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PARTS*FLOAT_W-1:0] part_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [FLOAT_W-1:0]           add_a,
  output logic [FLOAT_W-1:0]           add_b,
  output logic                         add_req,
  input  logic                         add_ack,
  input  logic [FLOAT_W-1:0]           add_result,
  output logic [FLOAT_W-1:0]           out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun
);

  // k reaches NUM_PARTS at most, so one extra bit keeps it from wrapping
  localparam int            KW     = $clog2(NUM_PARTS) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_PARTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [NUM_PARTS*FLOAT_W-1:0] buf_q, buf_d;
  logic [FLOAT_W-1:0]           acc_q, acc_d;
  logic [KW-1:0]                k_q, k_d;
  logic                         overrun_q, overrun_d;
  logic                         add_req_q, add_req_d;
  logic [FLOAT_W-1:0]           add_b_q, add_b_d;
  logic                         out_valid_q, out_valid_d;
  logic                         in_ready_q, in_ready_d;
  logic                         accept_s;

  // Word idx of the sample buffer. An out-of-range index returns zero.
  function automatic logic [FLOAT_W-1:0] word_sel(
    input logic [NUM_PARTS*FLOAT_W-1:0] v,
    input logic [KW-1:0]                idx
  );
    word_sel = '0;
    for (int i = 0; i < NUM_PARTS; i++) begin
      word_sel = (idx == KW'(i)) ? v[i*FLOAT_W +: FLOAT_W] : word_sel;
    end
  endfunction

  // Decide whether the offered sample set is taken this cycle
  always_comb begin
`ifdef FIR_ADD_SCHED_PASS_EN
    accept_s = in_valid && ((state_q == ST_IDLE) ||
                            ((state_q == ST_DONE) && out_ready));
`else
    accept_s = in_valid && (state_q == ST_IDLE);
`endif
  end

  // Next-state, datapath and registered output decode
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    acc_d     = acc_q;
    k_d       = k_q;
    overrun_d = overrun_q;
    if (accept_s) begin
      buf_d   = part_in;
      acc_d   = part_in[FLOAT_W-1:0];
      k_d     = KW'(1);
      state_d = (NUM_PARTS == 1) ? ST_DONE : ST_ACCUM;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ACCUM: begin
          // A set offered here is dropped and the buffer is left intact
          overrun_d = overrun_q | in_valid;
          if (add_ack) begin
            acc_d   = add_result;
            k_d     = k_q + KW'(1);
            state_d = (k_q == K_LAST) ? ST_DONE : ST_ACCUM;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_DONE: begin
          overrun_d = overrun_q | in_valid;
          state_d   = out_ready ? ST_IDLE : ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // Outputs are decoded from the next state so they leave a flop
    add_req_d   = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
    add_b_d     = word_sel(buf_d, k_d);
  end

  // State and output registers, with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      overrun_q   <= 1'b0;
      add_req_q   <= 1'b0;
      add_b_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      overrun_q   <= overrun_d;
      add_req_q   <= add_req_d;
      add_b_q     <= add_b_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign add_req   = add_req_q;
  assign add_a     = acc_q;
  assign add_b     = add_b_q;
  assign out_data  = acc_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_add_sched.sv
// Self-checking bench for fir_add_sched.
// The bench builds two instances: NUM_PARTS=4 and NUM_PARTS=1. The bench
// itself plays the shared FPU. It adds either as fp32 or as plain integers.
module tb_fir_add_sched;
  localparam int FW = 32;
  localparam int N4 = 4;

  typedef logic [31:0] words4_t [4];
  typedef struct {
    words4_t     p;
    logic [31:0] sum;
    int          delay;
  } vec_t;

  logic clk;
  logic rst;

  logic [N4*FW-1:0] part_in4;
  logic             in_valid4, in_ready4, add_req4, add_ack4;
  logic [FW-1:0]    add_a4, add_b4, add_result4, out_data4;
  logic             out_valid4, out_ready4, overrun4;

  logic [FW-1:0]    part_in1;
  logic             in_valid1, in_ready1, add_req1, add_ack1;
  logic [FW-1:0]    add_a1, add_b1, add_result1, out_data1;
  logic             out_valid1, out_ready1, overrun1;

  int total = 0;
  int bad   = 0;

  bit use_float = 1'b1;
  bit ack_tie   = 1'b0;
  int ack_delay = 2;
  logic [31:0] log_a[$];
  logic [31:0] log_b[$];
  bit seen_req1 = 1'b0;

  fir_add_sched #(.NUM_PARTS(N4), .FLOAT_W(FW)) dut4 (
    .clk(clk), .rst(rst), .part_in(part_in4), .in_valid(in_valid4),
    .in_ready(in_ready4), .add_a(add_a4), .add_b(add_b4), .add_req(add_req4),
    .add_ack(add_ack4), .add_result(add_result4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .overrun(overrun4)
  );

  fir_add_sched #(.NUM_PARTS(1), .FLOAT_W(FW)) dut1 (
    .clk(clk), .rst(rst), .part_in(part_in1), .in_valid(in_valid1),
    .in_ready(in_ready1), .add_a(add_a1), .add_b(add_b1), .add_req(add_req1),
    .add_ack(add_ack1), .add_result(add_result1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .overrun(overrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // fp32 helpers for positive, normal values
  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    m = 1.0 + real'(int'(b[22:0])) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return m;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real x;
    int  e;
    int  mant;
    logic [7:0]  ex;
    logic [22:0] mf;
    if (r <= 0.0) return 32'd0;
    x = r;
    e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    mant = $rtoi((x - 1.0) * 8388608.0);
    ex = 8'(e + 127);
    mf = 23'(mant);
    return {1'b0, ex, mf};
  endfunction

  function automatic logic [31:0] fpu_op(input logic [31:0] a, input logic [31:0] b);
    if (use_float) return r2f(f2r(a) + f2r(b));
    else           return a + b;
  endfunction

  function automatic logic [N4*FW-1:0] pack4(input words4_t p);
    logic [N4*FW-1:0] v;
    for (int i = 0; i < N4; i++) v[i*FW +: FW] = p[i];
    return v;
  endfunction

  // Shared-adder model: tied-high ack, or an ack after ack_delay request cycles
  initial begin
    int wait_cnt;
    wait_cnt    = 0;
    add_ack4    = 1'b0;
    add_result4 = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_tie) begin
        add_ack4    = 1'b1;
        add_result4 = fpu_op(add_a4, add_b4);
        if (add_req4) begin
          log_a.push_back(add_a4);
          log_b.push_back(add_b4);
        end
        wait_cnt = 0;
      end else if (add_ack4) begin
        add_ack4 = 1'b0;
        wait_cnt = 0;
      end else if (add_req4) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          add_ack4    = 1'b1;
          add_result4 = fpu_op(add_a4, add_b4);
          log_a.push_back(add_a4);
          log_b.push_back(add_b4);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Records whether the single-part instance ever requests an add
  initial begin
    forever begin
      @(negedge clk);
      if (add_req1 === 1'b1) seen_req1 = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    log_a.delete();
    log_b.delete();
  endtask

  // Offers a set for one cycle and returns at the negedge after the acceptance edge
  task automatic offer4(input words4_t p);
    part_in4  = pack4(p);
    in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
  endtask

  task automatic wait_out4(output int cycles, output bit ok);
    cycles = 1;
    while (!out_valid4 && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    ok = out_valid4;
  endtask

  // One full sample set on the 4-part instance, then checks of the operand order
  task automatic run4(input words4_t p, input logic [31:0] exp, input int delay, input int hold);
    int cyc;
    bit ok;
    logic [31:0] exp_a;
    ack_tie    = (delay == 0);
    ack_delay  = delay;
    out_ready4 = (hold == 0);
    log_a.delete();
    log_b.delete();
    offer4(p);
    wait_out4(cyc, ok);
    check("out_valid_timeout", 32'(ok), 32'd1);
    if (delay == 0) check("latency_tied_ack", 32'(cyc), 32'(N4));
    check("out_data", out_data4, exp);
    check("ack_count", 32'(log_b.size()), 32'd3);
    exp_a = p[0];
    for (int i = 0; i < 3; i++) begin
      if (i < log_b.size()) begin
        check("add_b_seq", log_b[i], p[i+1]);
        check("add_a_seq", log_a[i], exp_a);
      end
      exp_a = fpu_op(exp_a, p[i+1]);
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("hold_valid", 32'(out_valid4), 32'd1);
      check("hold_data", out_data4, exp);
      out_ready4 = 1'b1;
    end
    @(negedge clk);
    check("idle_after", 32'(in_ready4), 32'd1);
    check("valid_drop", 32'(out_valid4), 32'd0);
  endtask

  initial begin
    vec_t tbl[4];
    words4_t other;
    words4_t rp;
    logic [31:0] rsum;
    int cyc;
    bit ok;

    tbl[0].p[0] = 32'h3F800000; tbl[0].p[1] = 32'h40000000;
    tbl[0].p[2] = 32'h40400000; tbl[0].p[3] = 32'h40800000;
    tbl[0].sum  = 32'h41200000; tbl[0].delay = 2;
    tbl[1].p[0] = 32'h3F000000; tbl[1].p[1] = 32'h3E800000;
    tbl[1].p[2] = 32'h3E000000; tbl[1].p[3] = 32'h3E000000;
    tbl[1].sum  = 32'h3F800000; tbl[1].delay = 3;
    tbl[2].p[0] = 32'h41000000; tbl[2].p[1] = 32'h41000000;
    tbl[2].p[2] = 32'h41800000; tbl[2].p[3] = 32'h42000000;
    tbl[2].sum  = 32'h42800000; tbl[2].delay = 0;
    tbl[3].p[0] = 32'h3FC00000; tbl[3].p[1] = 32'h40200000;
    tbl[3].p[2] = 32'h40400000; tbl[3].p[3] = 32'h3F800000;
    tbl[3].sum  = 32'h41000000; tbl[3].delay = 1;
    other[0] = 32'h42C80000; other[1] = 32'h42C80000;
    other[2] = 32'h42C80000; other[3] = 32'h42C80000;

    rst = 1'b1;
    part_in4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b1;
    part_in1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    add_ack1 = 1'b1; add_result1 = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_add_req", 32'(add_req4), 32'd0);
    check("rst_out_valid", 32'(out_valid4), 32'd0);
    check("rst_in_ready", 32'(in_ready4), 32'd1);
    check("rst_overrun", 32'(overrun4), 32'd0);
    check("rst_out_data", out_data4, 32'd0);
    check("rst1_in_ready", 32'(in_ready1), 32'd1);
    check("rst1_out_valid", 32'(out_valid1), 32'd0);

    // Table of fp32 sets
    for (int t = 0; t < 4; t++) begin
      run4(tbl[t].p, tbl[t].sum, tbl[t].delay, 0);
    end
    check("no_overrun_tbl", 32'(overrun4), 32'd0);

    // Single part: no add request, result on the next cycle, ack ignored
    seen_req1 = 1'b0;
    part_in1  = 32'h40B00000;
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    check("n1_out_valid", 32'(out_valid1), 32'd1);
    check("n1_out_data", out_data1, 32'h40B00000);
    repeat (2) @(negedge clk);
    check("n1_hold_data", out_data1, 32'h40B00000);
    out_ready1 = 1'b1;
    @(negedge clk);
    check("n1_idle", 32'(in_ready1), 32'd1);
    check("n1_valid_drop", 32'(out_valid1), 32'd0);
    check("n1_no_add_req", 32'(seen_req1), 32'd0);

    // A set offered mid-accumulation is dropped and latches overrun
    ack_tie = 1'b0; ack_delay = 2; out_ready4 = 1'b1;
    log_a.delete(); log_b.delete();
    offer4(tbl[0].p);
    @(negedge clk);
    part_in4 = pack4(other);
    in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    check("overrun_set", 32'(overrun4), 32'd1);
    wait_out4(cyc, ok);
    check("ovr_timeout", 32'(ok), 32'd1);
    check("ovr_first_result", out_data4, tbl[0].sum);
    check("ovr_last_add_b", log_b.size() > 0 ? log_b[log_b.size()-1] : 32'd0, 32'h40800000);
    @(negedge clk);
    run4(tbl[1].p, tbl[1].sum, 1, 0);
    check("overrun_sticky", 32'(overrun4), 32'd1);
    do_reset();
    @(negedge clk);
    check("overrun_cleared", 32'(overrun4), 32'd0);

    // Reset while an add is requested and acknowledged on the same edge
    ack_tie = 1'b1; out_ready4 = 1'b1;
    offer4(tbl[0].p);
    check("pre_rst_add_req", 32'(add_req4), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_add_req", 32'(add_req4), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid4), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready4), 32'd1);
    check("mid_rst_overrun", 32'(overrun4), 32'd0);
    check("mid_rst_out_data", out_data4, 32'd0);
    check("mid_rst_add_a", add_a4, 32'd0);
    @(negedge clk);
    check("post_rst_idle", 32'(add_req4), 32'd0);
    check("post_rst_data", out_data4, 32'd0);

    // Output back-pressure for 10 cycles, then a set offered on the exit cycle
    ack_tie = 1'b0; ack_delay = 1; out_ready4 = 1'b0;
    offer4(tbl[2].p);
    wait_out4(cyc, ok);
    check("bp_timeout", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid4), 32'd1);
      check("bp_data", out_data4, tbl[2].sum);
      check("bp_in_ready", 32'(in_ready4), 32'd0);
    end
    log_a.delete(); log_b.delete();
    out_ready4 = 1'b1;
    part_in4   = pack4(tbl[3].p);
    in_valid4  = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
`ifdef FIR_ADD_SCHED_PASS_EN
    check("pass_add_req", 32'(add_req4), 32'd1);
    check("pass_overrun", 32'(overrun4), 32'd0);
    wait_out4(cyc, ok);
    check("pass_timeout", 32'(ok), 32'd1);
    check("pass_result", out_data4, tbl[3].sum);
    check("pass_overrun_end", 32'(overrun4), 32'd0);
    @(negedge clk);
`else
    check("nopass_idle", 32'(in_ready4), 32'd1);
    check("nopass_add_req", 32'(add_req4), 32'd0);
    check("nopass_overrun", 32'(overrun4), 32'd1);
`endif
    do_reset();
    @(negedge clk);

    // Random integer sets against a plain running-sum model
    use_float = 1'b0;
    for (int r = 0; r < 20; r++) begin
      rsum = 32'd0;
      for (int i = 0; i < N4; i++) begin
        rp[i] = $urandom;
        rsum  = rsum + rp[i];
      end
      run4(rp, rsum, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    check("rand_no_overrun", 32'(overrun4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_add_sched.md
FIR_ADD_SCHED -- requirements
Module: fir_add_sched

Interface
REQ-001 Parameter NUM_PARTS, default 80, meaning: number of LUT partial results summed per output sample (>=1).
REQ-002 Parameter FLOAT_W, default 32, meaning: width of one floatType word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 part_in  input  NUM_PARTS*FLOAT_W  partial results, word k at [k*FLOAT_W +: FLOAT_W].
REQ-006 in_valid  input  1  part_in holds a new sample set.
REQ-007 in_ready  output  1  scheduler can accept a sample set.
REQ-008 add_a, add_b  output  FLOAT_W each  operands to the shared FPU ADD.
REQ-009 add_req  output  1  operands valid, add requested.
REQ-010 add_ack  input  1  shared adder completed; add_result valid this cycle.
REQ-011 add_result  input  FLOAT_W  sum add_a+add_b.
REQ-012 out_data  output  FLOAT_W  filter output sample.
REQ-013 out_valid, out_ready  output/input  1 each  output handshake.
REQ-014 overrun  output  1  sticky: a sample set was offered while busy.

Function
REQ-015 States SHALL be IDLE, ACCUM, DONE.
REQ-016 IDLE: in_ready=1; on in_valid, latch all of part_in into an internal buffer, set acc=part[0] and k=1, go to ACCUM (to DONE if NUM_PARTS==1).
REQ-017 ACCUM: add_req=1, add_a=acc, add_b=part[k]; operands SHALL stay stable while add_ack=0.
REQ-018 On add_ack in ACCUM: acc<=add_result, k<=k+1; when k==NUM_PARTS-1, go to DONE.
REQ-019 DONE: out_valid=1, out_data=acc; on out_ready, go to IDLE.
REQ-020 add_ack outside ACCUM SHALL be ignored.
REQ-021 in_valid while not IDLE SHALL leave the buffer untouched, drop the set, and set overrun=1 until reset.
REQ-022 Summation order SHALL be strictly sequential, part[0] first, so results match the reference tree only to FPU rounding; no arithmetic inside the block.
REQ-023 Counter k SHALL be $clog2(NUM_PARTS)+1 bits and never wrap.
REQ-024 Latency, add_ack tied high: DONE entered NUM_PARTS-1 edges after the acceptance edge; NUM_PARTS==1: at the acceptance edge.
REQ-025 add_req and out_valid SHALL be registered-state decodes, never combinational on inputs.

Reset
REQ-026 rst at any edge, including mid-ACCUM with add_req high, SHALL force IDLE next cycle.
REQ-027 Reset values: add_req=0, out_valid=0, in_ready=1, overrun=0, out_data=0, acc=0, k=0.
REQ-028 An add_ack in the same cycle as rst SHALL be discarded.

Configuration
REQ-029 Macro FIR_ADD_SCHED_PASS_EN: when defined, in_valid in DONE with out_ready=1 SHALL be accepted in the same cycle (back-to-back, no IDLE bubble) and SHALL not set overrun.
REQ-030 Without FIR_ADD_SCHED_PASS_EN, only IDLE accepts, and REQ-021 applies in DONE.

Verification
REQ-031 NUM_PARTS=4, parts 1.0,2.0,3.0,4.0, add_ack 2 cycles after each add_req -> out_data=10.0, out_valid after exactly 3 acks, add_b sequence 2.0,3.0,4.0.
REQ-032 NUM_PARTS=1, part 5.5 -> add_req never rises, out_valid next cycle with 5.5.
REQ-033 in_valid pulsed mid-ACCUM -> overrun=1, result of first set unchanged, stays 1 until rst.
REQ-034 rst asserted with add_req=1 and add_ack=1 same cycle -> next cycle IDLE, all outputs at reset values.
REQ-035 out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0 (without macro).
REQ-036 Macro defined, two sets offered back-to-back with out_ready=1 -> second accepted on DONE exit cycle, overrun stays 0.
